// File: rtl/kgp_data_mem.sv
// Data-memory responder for the KGPRISC core data port.
// Word-organised RAM with byte-lane writes, registered read with
// write-first forwarding, a post-reset clear sweep gated by mem_ready,
// and a sticky capture of the first faulting address.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_CLEAR    | zeroing mem[clr_cnt], one word per cycle; port gated off
// S_IDLE_WAIT| single-cycle hold when the sweep is skipped; port gated off
// S_READY    | accesses honoured; terminal until the next reset
module kgp_data_mem #(
    parameter int unsigned ADDR_W         = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        start_n,
    input  logic [31:0] DA,
    input  logic [31:0] write_data,
    input  logic [3:0]  wea,
    output logic [31:0] doutd,
    output logic        mem_ready,
    output logic        addr_err,
    output logic [31:0] err_addr
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR     = 2'd0,
        S_IDLE_WAIT = 2'd1,
        S_READY     = 2'd2
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE_WAIT;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [31:0]       doutd_q, doutd_d;
    logic              addr_err_q, addr_err_d;
    logic [31:0]       err_addr_q, err_addr_d;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              legal;
    logic [31:0]       old_word;
    logic [31:0]       merged_word;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_word;

    // Out-of-range addresses are faults; the high bits are never dropped,
    // so no index aliasing can occur.
    assign word_idx = DA[ADDR_W+1:2];
    assign legal    = (DA[1:0] == 2'b00) && ((DA >> (ADDR_W + 2)) == 32'd0);
    assign old_word = mem[word_idx];

    // Byte-lane merge of the store data over the current word; this is both
    // what gets written and what is forwarded to doutd on the same edge.
    always_comb begin
        merged_word = old_word;
        for (int b = 0; b < 4; b++) begin
            if (wea[b]) begin
                merged_word[8*b +: 8] = write_data[8*b +: 8];
            end
        end
    end

    // Next-state, RAM write port selection and output register updates.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        doutd_d    = doutd_q;
        addr_err_d = addr_err_q;
        err_addr_d = err_addr_q;
        wr_en      = 1'b0;
        wr_idx     = word_idx;
        wr_word    = merged_word;

        case (state_q)
            S_CLEAR: begin
                wr_en     = 1'b1;
                wr_idx    = clr_cnt_q;
                wr_word   = 32'd0;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                doutd_d   = 32'd0;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = S_READY;
                end
            end
            S_IDLE_WAIT: begin
                doutd_d = 32'd0;
                state_d = S_READY;
            end
            S_READY: begin
                if (legal) begin
                    wr_en   = |wea;
                    doutd_d = merged_word;
                end else begin
                    doutd_d = 32'd0;
                    if (!addr_err_q) begin
                        addr_err_d = 1'b1;
                        err_addr_d = DA;
                    end
                end
            end
            default: begin
                doutd_d = 32'd0;
                state_d = RESET_STATE;
            end
        endcase
    end

    // Control and output registers; async reset restarts any sweep from 0.
    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            state_q    <= RESET_STATE;
            clr_cnt_q  <= '0;
            doutd_q    <= 32'd0;
            addr_err_q <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            doutd_q    <= doutd_d;
            addr_err_q <= addr_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // RAM array: single write port shared by the clear sweep and core stores.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_word;
        end
    end

    assign doutd     = doutd_q;
    assign mem_ready = (state_q == S_READY);
    assign addr_err  = addr_err_q;
    assign err_addr  = err_addr_q;

endmodule
